// File: rtl/load_store_unit.sv
// RV32I load/store unit between the MEM stage and a word-wide data memory.
// Sub-word stores use a registered read-modify-write; misaligned or illegal requests never reach memory.
module load_store_unit #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [DW-1:0] resp_rdata,
    output logic [AW-1:0] memAdr,
    output logic [DW-1:0] writeData,
    output logic          memWrite,
    input  logic [DW-1:0] readData
);

    localparam int unsigned SHIFT_W = 5;

    typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, DONE} lsuState;

    lsuState       state;
    logic          storeQ;
    logic [2:0]    funct3Q;
    logic [AW-1:0] adrQ;
    logic [DW-1:0] wdataQ;
    logic          memWriteQ;

    logic               accept;
    logic               reqErr;
    logic [SHIFT_W-1:0] laneShift;
    logic [DW-1:0]      loadShifted;
    logic [DW-1:0]      loadData;
    logic [DW-1:0]      storeMask;
    logic [DW-1:0]      mergedWord;

    assign accept      = req_valid & req_ready;
    assign memAdr      = {adrQ[AW-1:2], 2'b00};
    // A write pending in the reset cycle must not reach memory.
    assign memWrite    = memWriteQ & ~rst;
    assign laneShift   = {adrQ[1:0], 3'b000};
    assign loadShifted = readData >> laneShift;
    assign mergedWord  = (readData & ~storeMask) | ((wdataQ << laneShift) & storeMask);

    // Alignment and funct3 legality of the incoming request.
    always_comb begin
        reqErr = 1'b1;
        case (req_funct3)
            3'b000:  reqErr = 1'b0;
            3'b100:  reqErr = req_store;
            3'b001:  reqErr = req_adr[0];
            3'b101:  reqErr = req_store | req_adr[0];
            3'b010:  reqErr = |req_adr[1:0];
            default: reqErr = 1'b1;
        endcase
    end

    always_comb begin
        loadData = '0;
        case (funct3Q)
            3'b000:  loadData = {{24{loadShifted[7]}}, loadShifted[7:0]};
            3'b100:  loadData = {24'h0, loadShifted[7:0]};
            3'b001:  loadData = {{16{loadShifted[15]}}, loadShifted[15:0]};
            3'b101:  loadData = {16'h0, loadShifted[15:0]};
            3'b010:  loadData = readData;
            default: loadData = '0;
        endcase
    end

    always_comb begin
        storeMask = '1;
        case (funct3Q[1:0])
            2'b00:   storeMask = DW'(32'h0000_00FF) << laneShift;
            2'b01:   storeMask = DW'(32'h0000_FFFF) << laneShift;
            default: storeMask = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            memWriteQ  <= 1'b0;
            writeData  <= '0;
            storeQ     <= 1'b0;
            funct3Q    <= '0;
            adrQ       <= '0;
            wdataQ     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        storeQ    <= req_store;
                        funct3Q   <= req_funct3;
                        adrQ      <= req_adr;
                        wdataQ    <= req_wdata;
                        req_ready <= 1'b0;
                        if (reqErr) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_store) begin
                            state <= LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            state     <= WRITE;
                            memWriteQ <= 1'b1;
                            writeData <= req_wdata;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                LOAD: begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                    resp_rdata <= storeQ ? '0 : loadData;
                end
                // The merged word is captured here and written in WRITE.
                READ: begin
                    state     <= WRITE;
                    memWriteQ <= 1'b1;
                    writeData <= mergedWord;
                end
                WRITE: begin
                    state      <= DONE;
                    memWriteQ  <= 1'b0;
                    writeData  <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus back-to-back and reset corner sequences.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] memAdr;
    logic [31:0] writeData;
    logic        memWrite;
    logic [31:0] readData;

    load_store_unit #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_adr    (req_adr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .memAdr     (memAdr),
        .writeData  (writeData),
        .memWrite   (memWrite),
        .readData   (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1 KiB data memory with a bench-side preload port.
    logic [31:0] mem [0:255];
    logic        preWe;
    logic [7:0]  preIdx;
    logic [31:0] preData;
    int          writeCnt;

    assign readData = mem[memAdr[9:2]];

    always @(posedge clk) begin
        if (memWrite) begin
            mem[memAdr[9:2]] <= writeData;
            writeCnt <= writeCnt + 1;
        end else if (preWe) begin
            mem[preIdx] <= preData;
        end
    end

    int passCnt = 0;
    int checkCnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic preload(input logic [31:0] adr, input logic [31:0] data);
        @(negedge clk);
        preWe   = 1'b1;
        preIdx  = adr[9:2];
        preData = data;
        @(negedge clk);
        preWe = 1'b0;
    endtask

    task automatic runReq(input logic st, input logic [2:0] f3, input logic [31:0] adr,
                          input logic [31:0] wd, output logic [31:0] rdata,
                          output logic err, output int lat, output int nWrites);
        int w0;
        int g;
        w0 = writeCnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_adr    = adr;
        req_wdata  = wd;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g == 20) chk("ready_timeout", 32'(g), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(negedge clk);
        nWrites = writeCnt - w0;
        chk("pulse_end_valid", {31'b0, resp_valid}, 32'd0);
        chk("pulse_end_err", {31'b0, resp_err}, 32'd0);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
        chk("rdata_hold", resp_rdata, rdata);
    endtask

    typedef struct {
        bit          pre;
        logic [31:0] preWord;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        bit          expErr;
        int          expLat;
        int          expWrites;
        bit          chkWord;
        logic [31:0] expWord;
    } vecT;

    localparam int NV = 19;
    vecT vec [NV];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          nw;
        int          w0;
        int          issued;
        int          got;
        int          cyc;
        int          extra;
        logic [31:0] exp;

        vec[0]  = '{1, 32'h8899AABB, 0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 0, 2, 0, 0, 32'h0};
        vec[1]  = '{0, 32'h0, 0, 3'b100, 32'h101, 32'h0, 32'h000000AA, 0, 2, 0, 0, 32'h0};
        vec[2]  = '{1, 32'h11223344, 1, 3'b000, 32'h102, 32'h000000EE, 32'h0, 0, 3, 1, 1, 32'h11EE3344};
        vec[3]  = '{0, 32'h0, 0, 3'b010, 32'h100, 32'h0, 32'h11EE3344, 0, 2, 0, 0, 32'h0};
        vec[4]  = '{1, 32'h11223344, 1, 3'b001, 32'h102, 32'h0000CAFE, 32'h0, 0, 3, 1, 1, 32'hCAFE3344};
        vec[5]  = '{0, 32'h0, 0, 3'b001, 32'h102, 32'h0, 32'hFFFFCAFE, 0, 2, 0, 0, 32'h0};
        vec[6]  = '{0, 32'h0, 0, 3'b101, 32'h102, 32'h0, 32'h0000CAFE, 0, 2, 0, 0, 32'h0};
        vec[7]  = '{0, 32'h0, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0};
        vec[8]  = '{0, 32'h0, 1, 3'b001, 32'h103, 32'h1234, 32'h0, 1, 1, 0, 1, 32'hCAFE3344};
        vec[9]  = '{0, 32'h0, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0};
        vec[10] = '{0, 32'h0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 2, 1, 1, 32'hDEADBEEF};
        vec[11] = '{0, 32'h0, 0, 3'b000, 32'h107, 32'h0, 32'hFFFFFFDE, 0, 2, 0, 0, 32'h0};
        vec[12] = '{0, 32'h0, 0, 3'b001, 32'h104, 32'h0, 32'hFFFFBEEF, 0, 2, 0, 0, 32'h0};
        vec[13] = '{1, 32'h80123456, 0, 3'b100, 32'hFFFFFFFF, 32'h0, 32'h00000080, 0, 2, 0, 0, 32'h0};
        vec[14] = '{0, 32'h0, 0, 3'b000, 32'hFFFFFFFF, 32'h0, 32'hFFFFFF80, 0, 2, 0, 0, 32'h0};
        vec[15] = '{0, 32'h0, 0, 3'b010, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0};
        vec[16] = '{0, 32'h0, 1, 3'b100, 32'h100, 32'h55, 32'h0, 1, 1, 0, 1, 32'hCAFE3344};
        vec[17] = '{0, 32'h0, 1, 3'b000, 32'h100, 32'hFFFFFF77, 32'h0, 0, 3, 1, 1, 32'hCAFE3377};
        vec[18] = '{0, 32'h0, 0, 3'b000, 32'h101, 32'h0, 32'h00000033, 0, 2, 0, 0, 32'h0};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_adr    = 32'h0;
        req_wdata  = 32'h0;
        preWe      = 1'b0;
        preIdx     = 8'h0;
        preData    = 32'h0;
        writeCnt   = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_memwrite", {31'b0, memWrite}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (vec[i].pre) preload(vec[i].adr, vec[i].preWord);
            runReq(vec[i].st, vec[i].f3, vec[i].adr, vec[i].wdata, rd, er, lat, nw);
            chk($sformatf("v%0d_rdata", i), rd, vec[i].expRdata);
            chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vec[i].expErr});
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vec[i].expLat));
            chk($sformatf("v%0d_writes", i), 32'(nw), 32'(vec[i].expWrites));
            if (vec[i].chkWord) chk($sformatf("v%0d_memword", i), mem[vec[i].adr[9:2]], vec[i].expWord);
        end

        // Back-to-back sw/lw pairs with req_valid held high.
        w0 = writeCnt;
        issued = 0;
        got = 0;
        cyc = 0;
        while ((issued < 8 || got < 8) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) begin
                exp = (got % 2 == 1) ? 32'h1000_0000 + 32'(got / 2) : 32'h0;
                chk($sformatf("b2b_rdata%0d", got), resp_rdata, exp);
                chk("b2b_ready_in_done", {31'b0, req_ready}, 32'd0);
                got++;
            end
            if (issued < 8) begin
                req_valid  = 1'b1;
                req_store  = (issued % 2 == 0);
                req_funct3 = 3'b010;
                req_adr    = 32'h200 + 32'(4 * (issued / 2));
                req_wdata  = 32'h1000_0000 + 32'(issued / 2);
                if (req_ready) issued++;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        chk("b2b_issued", 32'(issued), 32'd8);
        chk("b2b_responses", 32'(got), 32'd8);
        chk("b2b_extra_resp", 32'(extra), 32'd0);
        chk("b2b_writes", 32'(writeCnt - w0), 32'd4);

        // Reset during the READ cycle of an sb.
        preload(32'h300, 32'h55667788);
        w0 = writeCnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_adr    = 32'h300;
        req_wdata  = 32'h11;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstrd_memwrite_in_rst", {31'b0, memWrite}, 32'd0);
        rst = 1'b0;
        chk("rstrd_ready", {31'b0, req_ready}, 32'd1);
        chk("rstrd_valid", {31'b0, resp_valid}, 32'd0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || memWrite) extra++;
        end
        chk("rstrd_no_activity", 32'(extra), 32'd0);
        chk("rstrd_memword", mem[8'hC0], 32'h55667788);
        chk("rstrd_writes", 32'(writeCnt - w0), 32'd0);

        // Reset during the WRITE cycle of an sw.
        preload(32'h304, 32'h01020304);
        w0 = writeCnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_adr    = 32'h304;
        req_wdata  = 32'hAAAAAAAA;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstwr_memwrite_pre", {31'b0, memWrite}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwr_memwrite_gated", {31'b0, memWrite}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstwr_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rstwr_memword", mem[8'hC1], 32'h01020304);
        chk("rstwr_writes", 32'(writeCnt - w0), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
